// File: rtl/stage_ex_mc_pkg.sv
// Shared types for the LC-3b style execute stage.
// Holds the execute-op / ALU-op / operand-select encodings, the control
// bundle handed over by the ID/EX register, and the stage FSM encoding.
// No ports: this file is imported by the execute stage and its multiplier.

package stage_ex_mc_pkg;

   // Width of the instruction word the immediate fields are cut from.
   localparam int IR_W = 16;

   typedef enum logic [1:0] {
      EX_ALU = 2'd0,
      EX_PC  = 2'd1,
      EX_MUL = 2'd2
   } lc3b_ex_op_t;

   typedef enum logic [2:0] {
      ALU_ADD   = 3'd0,
      ALU_AND   = 3'd1,
      ALU_NOT   = 3'd2,
      ALU_PASSB = 3'd3,
      ALU_SLL   = 3'd4,
      ALU_SRL   = 3'd5,
      ALU_SRA   = 3'd6
   } lc3b_alu_op_t;

   typedef enum logic [2:0] {
      B_SR2   = 3'd0,
      B_IMM5  = 3'd1,
      B_IMM4  = 3'd2,
      B_OFF6  = 3'd3,
      B_OFF6W = 3'd4
   } lc3b_alu_b_sel_t;

   typedef enum logic {
      PCA_OFF9  = 1'b0,
      PCA_OFF11 = 1'b1
   } lc3b_pc_adder_sel_t;

   typedef struct packed {
      lc3b_ex_op_t        ex_op;
      lc3b_alu_op_t       alu_op;
      lc3b_alu_b_sel_t    alu_b_sel;
      lc3b_pc_adder_sel_t pc_adder_sel;
   } lc3b_ex_ctrl_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } lc3b_ex_state_t;

endpackage

// File: rtl/stage_ex_mc_mul_iter.sv
// Iterative shift-and-add multiplier, MUL_BITS multiplier bits per cycle.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   start        load operands, clear accumulator, arm the step counter
//   a, b         multiplicand / multiplier, sampled only on start
//   done         high during the cycle whose edge retires the final step
//   product      accumulator = low WIDTH bits of a*b once the last step retired
// The caller owns sequencing; this block only counts its steps down to zero
// and then sits idle until the next start.

module mul_iter
   import stage_ex_mc_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int MUL_BITS = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int STEPS = WIDTH / MUL_BITS;
   localparam int CNT_W = $clog2(STEPS + 1);

   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] partial;

   // The multiplicand is pre-shifted each step instead of shifting the
   // partial product, so the running shift amount never has to be stored.
   always_comb begin
      partial = '0;
      for (int j = 0; j < MUL_BITS; j++) begin
         if (b_q[j]) begin
            partial = partial + (a_q << j);
         end
      end
   end

   // Start always wins so a new multiply can abandon a flushed one that is
   // still counting down.
   always_comb begin
      a_d   = a_q;
      b_d   = b_q;
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (start) begin
         a_d   = a;
         b_d   = b;
         acc_d = '0;
         cnt_d = CNT_W'(STEPS);
      end else if (cnt_q != '0) begin
         acc_d = acc_q + partial;
         a_d   = a_q << MUL_BITS;
         b_d   = b_q >> MUL_BITS;
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q   <= '0;
         b_q   <= '0;
         acc_q <= '0;
         cnt_q <= '0;
      end else begin
         a_q   <= a_d;
         b_q   <= b_d;
         acc_q <= acc_d;
         cnt_q <= cnt_d;
      end
   end

   assign done    = (cnt_q == CNT_W'(1));
   assign product = acc_q;

endmodule

// File: rtl/stage_ex_mc.sv
// Execute stage with EX/MEM output register and an iterative multiplier.
// Ports:
//   clk, rst_n             clock / asynchronous active-low reset
//   valid_in               ID/EX holds a valid instruction
//   flush                  squash in-flight MUL and the output register
//   stall_in               MEM cannot accept; output register holds
//   ctrl                   ex_op / alu_op / alu_b_sel / pc_adder_sel
//   ir                     instruction word (immediate / offset fields)
//   pc                     incremented PC
//   sr1, sr2               register file operands
//   fwd_a_sel, fwd_b_sel   forwarding selects (0 = register file)
//   fwd_data               forwarded values, slot i-1 holds select i
//   busy                   stage cannot accept this cycle
//   valid_out              output register holds a valid result
//   alu_out                ALU result, PC (EX_PC ops) or MUL low word
//   pcn_out                PC + offset9/offset11 (non-MUL ops)
//   sr2_out                forwarded operand B, used as store data
// MUL ops leave pcn_out/sr2_out at their previous values.

module stage_ex_mc
   import stage_ex_mc_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int NUM_FWD  = 3,
   parameter int MUL_BITS = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         valid_in,
   input  logic                         flush,
   input  logic                         stall_in,
   input  lc3b_ex_ctrl_t                ctrl,
   input  logic [IR_W-1:0]              ir,
   input  logic [WIDTH-1:0]             pc,
   input  logic [WIDTH-1:0]             sr1,
   input  logic [WIDTH-1:0]             sr2,
   input  logic [$clog2(NUM_FWD)-1:0]   fwd_a_sel,
   input  logic [$clog2(NUM_FWD)-1:0]   fwd_b_sel,
   input  logic [(NUM_FWD-1)*WIDTH-1:0] fwd_data,
   output logic                         busy,
   output logic                         valid_out,
   output logic [WIDTH-1:0]             alu_out,
   output logic [WIDTH-1:0]             pcn_out,
   output logic [WIDTH-1:0]             sr2_out
);

   localparam int SEL_W = $clog2(NUM_FWD);

   lc3b_ex_state_t   state_q, state_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] alu_out_q, alu_out_d;
   logic [WIDTH-1:0] pcn_q, pcn_d;
   logic [WIDTH-1:0] sr2_q, sr2_d;

   logic [WIDTH-1:0] opnd_a, opnd_b, alu_b, alu_res, pcn_sum;
   logic [WIDTH-1:0] imm4, imm5, off6, off6w, off9, off11;
   logic             mul_start, mul_done;
   logic [WIDTH-1:0] mul_product;
   logic             unused_ir_bits;

   // Select values beyond the last forwarding slot fall back to the
   // register file rather than reading past fwd_data.
   always_comb begin
      opnd_a = sr1;
      opnd_b = sr2;
      for (int i = 1; i < NUM_FWD; i++) begin
         if (fwd_a_sel == SEL_W'(i)) begin
            opnd_a = fwd_data[(i-1)*WIDTH +: WIDTH];
         end
         if (fwd_b_sel == SEL_W'(i)) begin
            opnd_b = fwd_data[(i-1)*WIDTH +: WIDTH];
         end
      end
   end

   // Word offsets are pre-doubled so the PC adder and address ALU see byte offsets.
   assign imm4  = {{(WIDTH-4){1'b0}},   ir[3:0]};
   assign imm5  = {{(WIDTH-5){ir[4]}},  ir[4:0]};
   assign off6  = {{(WIDTH-6){ir[5]}},  ir[5:0]};
   assign off6w = {{(WIDTH-7){ir[5]}},  ir[5:0],  1'b0};
   assign off9  = {{(WIDTH-10){ir[8]}}, ir[8:0],  1'b0};
   assign off11 = {{(WIDTH-12){ir[10]}}, ir[10:0], 1'b0};

   assign unused_ir_bits = ^ir[IR_W-1:11];

   assign pcn_sum = pc + ((ctrl.pc_adder_sel == PCA_OFF11) ? off11 : off9);

   // Shift ops use only the low four bits of operand B as the amount.
   always_comb begin
      alu_b = opnd_b;
      case (ctrl.alu_b_sel)
         B_IMM5:  alu_b = imm5;
         B_IMM4:  alu_b = imm4;
         B_OFF6:  alu_b = off6;
         B_OFF6W: alu_b = off6w;
         default: alu_b = opnd_b;
      endcase

      alu_res = '0;
      case (ctrl.alu_op)
         ALU_ADD:   alu_res = opnd_a + alu_b;
         ALU_AND:   alu_res = opnd_a & alu_b;
         ALU_NOT:   alu_res = ~opnd_a;
         ALU_PASSB: alu_res = alu_b;
         ALU_SLL:   alu_res = opnd_a << alu_b[3:0];
         ALU_SRL:   alu_res = opnd_a >> alu_b[3:0];
         ALU_SRA:   alu_res = $signed(opnd_a) >>> alu_b[3:0];
         default:   alu_res = '0;
      endcase
   end

   mul_iter #(
      .WIDTH    (WIDTH),
      .MUL_BITS (MUL_BITS)
   ) u_mul_iter (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (opnd_a),
      .b       (opnd_b),
      .done    (mul_done),
      .product (mul_product)
   );

   // Flush beats stall, stall freezes the output register but lets a running
   // multiply keep stepping (it parks in DONE). Unstalled edges that produce
   // nothing clear valid_out. In IDLE with no stall busy is low, so valid_in
   // alone means accept.
   always_comb begin
      state_d   = state_q;
      valid_d   = valid_q;
      alu_out_d = alu_out_q;
      pcn_d     = pcn_q;
      sr2_d     = sr2_q;
      mul_start = 1'b0;
      if (flush) begin
         state_d = IDLE;
         valid_d = 1'b0;
      end else if (stall_in) begin
         if (state_q == MUL && mul_done) begin
            state_d = DONE;
         end
      end else begin
         case (state_q)
            IDLE: begin
               valid_d = 1'b0;
               if (valid_in) begin
                  if (ctrl.ex_op == EX_MUL) begin
                     mul_start = 1'b1;
                     state_d   = MUL;
                  end else begin
                     valid_d   = 1'b1;
                     alu_out_d = (ctrl.ex_op == EX_PC) ? pc : alu_res;
                     pcn_d     = pcn_sum;
                     sr2_d     = opnd_b;
                  end
               end
            end
            MUL: begin
               valid_d = 1'b0;
               if (mul_done) begin
                  state_d = DONE;
               end
            end
            DONE: begin
               valid_d   = 1'b1;
               alu_out_d = mul_product;
               state_d   = IDLE;
            end
            default: begin
               state_d = IDLE;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         valid_q   <= 1'b0;
         alu_out_q <= '0;
         pcn_q     <= '0;
         sr2_q     <= '0;
      end else begin
         state_q   <= state_d;
         valid_q   <= valid_d;
         alu_out_q <= alu_out_d;
         pcn_q     <= pcn_d;
         sr2_q     <= sr2_d;
      end
   end

   assign busy      = (state_q != IDLE) || (valid_q && stall_in);
   assign valid_out = valid_q;
   assign alu_out   = alu_out_q;
   assign pcn_out   = pcn_q;
   assign sr2_out   = sr2_q;

endmodule

// File: tb/tb_stage_ex_mc.sv
// Randomised scoreboard bench for stage_ex_mc.
// Stimulus pushes the expected result (value and arrival cycle) into a queue;
// a monitor pops and compares whenever the stage presents a new result.

module tb_stage_ex_mc;
   import stage_ex_mc_pkg::*;

   localparam int WIDTH    = 16;
   localparam int NUM_FWD  = 3;
   localparam int MUL_BITS = 1;
   localparam int SEL_W    = $clog2(NUM_FWD);
   localparam int STEPS    = WIDTH / MUL_BITS;

   logic                         clk = 1'b0;
   logic                         rst_n;
   logic                         valid_in, flush, stall_in;
   lc3b_ex_ctrl_t                ctrl;
   logic [15:0]                  ir;
   logic [WIDTH-1:0]             pc, sr1, sr2;
   logic [SEL_W-1:0]             fwd_a_sel, fwd_b_sel;
   logic [(NUM_FWD-1)*WIDTH-1:0] fwd_data;
   logic                         busy, valid_out;
   logic [WIDTH-1:0]             alu_out, pcn_out, sr2_out;

   typedef struct {
      lc3b_ex_ctrl_t    ctrl;
      logic [15:0]      ir;
      logic [WIDTH-1:0] pc, sr1, sr2;
      logic [SEL_W-1:0] asel, bsel;
      logic [WIDTH-1:0] fwd [NUM_FWD];
   } txn_t;

   typedef struct {
      logic [WIDTH-1:0] alu, pcn, sr2;
      int               cyc;
   } exp_t;

   exp_t             sb_q[$];
   exp_t             last_exp;
   exp_t             mon_e;
   logic [WIDTH-1:0] model_pcn = '0;
   logic [WIDTH-1:0] model_sr2 = '0;
   int               compared   = 0;
   int               mismatched = 0;
   int               cyc        = 0;
   bit               was_held;

   always #5 clk = ~clk;

   stage_ex_mc #(
      .WIDTH    (WIDTH),
      .NUM_FWD  (NUM_FWD),
      .MUL_BITS (MUL_BITS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_in  (valid_in),
      .flush     (flush),
      .stall_in  (stall_in),
      .ctrl      (ctrl),
      .ir        (ir),
      .pc        (pc),
      .sr1       (sr1),
      .sr2       (sr2),
      .fwd_a_sel (fwd_a_sel),
      .fwd_b_sel (fwd_b_sel),
      .fwd_data  (fwd_data),
      .busy      (busy),
      .valid_out (valid_out),
      .alu_out   (alu_out),
      .pcn_out   (pcn_out),
      .sr2_out   (sr2_out)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int sx(input int v, input int bits);
      return (v >= (1 << (bits - 1))) ? v - (1 << bits) : v;
   endfunction

   function automatic logic [WIDTH-1:0] pick(input txn_t t, input logic [SEL_W-1:0] sel,
                                             input logic [WIDTH-1:0] rf);
      if (sel == 0 || int'(sel) >= NUM_FWD) return rf;
      return t.fwd[sel];
   endfunction

   function automatic exp_t modelExec(input txn_t t);
      exp_t             e;
      logic [WIDTH-1:0] a, b, bb;
      int               off, sa;
      a = pick(t, t.asel, t.sr1);
      b = pick(t, t.bsel, t.sr2);
      case (t.ctrl.alu_b_sel)
         B_IMM5:  bb = WIDTH'(sx(int'(t.ir[4:0]), 5));
         B_IMM4:  bb = WIDTH'(int'(t.ir[3:0]));
         B_OFF6:  bb = WIDTH'(sx(int'(t.ir[5:0]), 6));
         B_OFF6W: bb = WIDTH'(2 * sx(int'(t.ir[5:0]), 6));
         default: bb = b;
      endcase
      case (t.ctrl.alu_op)
         ALU_ADD:   e.alu = a + bb;
         ALU_AND:   e.alu = a & bb;
         ALU_NOT:   e.alu = ~a;
         ALU_PASSB: e.alu = bb;
         ALU_SLL:   e.alu = a << bb[3:0];
         ALU_SRL:   e.alu = a >> bb[3:0];
         ALU_SRA: begin
            sa    = sx(int'(a), WIDTH);
            e.alu = WIDTH'(sa >>> bb[3:0]);
         end
         default:   e.alu = '0;
      endcase
      off = (t.ctrl.pc_adder_sel == PCA_OFF11) ? sx(int'(t.ir[10:0]), 11) : sx(int'(t.ir[8:0]), 9);
      e.pcn = t.pc + WIDTH'(2 * off);
      e.sr2 = b;
      if (t.ctrl.ex_op == EX_PC) e.alu = t.pc;
      if (t.ctrl.ex_op == EX_MUL) e.alu = WIDTH'(longint'(a) * longint'(b));
      e.cyc = 0;
      return e;
   endfunction

   function automatic txn_t randTxn(input int mul_pct);
      txn_t t;
      int   r = $urandom_range(0, 99);
      t.ctrl.ex_op        = (r < mul_pct) ? EX_MUL : ((r < mul_pct + 20) ? EX_PC : EX_ALU);
      t.ctrl.alu_op       = lc3b_alu_op_t'($urandom_range(0, 6));
      t.ctrl.alu_b_sel    = lc3b_alu_b_sel_t'($urandom_range(0, 4));
      t.ctrl.pc_adder_sel = lc3b_pc_adder_sel_t'($urandom_range(0, 1));
      t.ir   = 16'($urandom);
      t.pc   = WIDTH'($urandom);
      t.sr1  = WIDTH'($urandom);
      t.sr2  = WIDTH'($urandom);
      t.asel = SEL_W'($urandom_range(0, NUM_FWD - 1));
      t.bsel = SEL_W'($urandom_range(0, NUM_FWD - 1));
      for (int i = 0; i < NUM_FWD; i++) t.fwd[i] = WIDTH'($urandom);
      return t;
   endfunction

   function automatic txn_t plainTxn(input lc3b_ex_op_t op, input lc3b_alu_op_t aop,
                                     input lc3b_alu_b_sel_t bsel);
      txn_t t = randTxn(0);
      t.ctrl.ex_op     = op;
      t.ctrl.alu_op    = aop;
      t.ctrl.alu_b_sel = bsel;
      t.asel = '0;
      t.bsel = '0;
      return t;
   endfunction

   // ---------------- stimulus ----------------
   task automatic driveTxn(input txn_t t);
      ctrl      = t.ctrl;
      ir        = t.ir;
      pc        = t.pc;
      sr1       = t.sr1;
      sr2       = t.sr2;
      fwd_a_sel = t.asel;
      fwd_b_sel = t.bsel;
      for (int i = 1; i < NUM_FWD; i++) fwd_data[(i-1)*WIDTH +: WIDTH] = t.fwd[i];
   endtask

   task automatic driveJunk();
      driveTxn(randTxn(33));
      valid_in = 1'($urandom_range(0, 1));
      flush    = 1'b0;
   endtask

   task automatic pushExp(input exp_t e, input bit is_mul);
      if (is_mul) begin
         e.pcn = model_pcn;
         e.sr2 = model_sr2;
      end
      model_pcn = e.pcn;
      model_sr2 = e.sr2;
      sb_q.push_back(e);
   endtask

   // Issues one instruction into an idle stage, feeds ignored junk while a
   // MUL runs, then optionally holds the result with stall for post_stall cycles.
   task automatic applyStimulus(input txn_t t, input int stall_pct, input int done_stall,
                                input int post_stall);
      exp_t e;
      int   e0;
      bit   pushed;
      @(negedge clk);
      driveTxn(t);
      valid_in = 1'b1;
      stall_in = 1'b0;
      flush    = 1'b0;
      e0 = cyc + 1;
      #1 checkOutput("busy_at_issue", 32'(busy), 32'd0);
      e = modelExec(t);
      if (t.ctrl.ex_op != EX_MUL) begin
         e.cyc = e0;
         pushExp(e, 1'b0);
      end else begin
         pushed = 1'b0;
         for (int k = 1; k <= STEPS + 200 && !pushed; k++) begin
            @(negedge clk);
            driveJunk();
            if (k > STEPS && k <= STEPS + done_stall) stall_in = 1'b1;
            else stall_in = ($urandom_range(0, 99) < stall_pct);
            #1 checkOutput("busy_mul", 32'(busy), 32'd1);
            if (k > STEPS && !stall_in) begin
               e.cyc = e0 + k;
               pushExp(e, 1'b1);
               pushed = 1'b1;
            end
         end
         if (!pushed) checkOutput("mul_stall_budget", 32'd0, 32'd1);
      end
      for (int k = 0; k < post_stall; k++) begin
         @(negedge clk);
         driveJunk();
         valid_in = 1'b1;
         stall_in = 1'b1;
         #1 checkOutput("busy_hold", 32'(busy), 32'd1);
      end
   endtask

   task automatic flushMul(input txn_t t, input int flush_k);
      @(negedge clk);
      driveTxn(t);
      valid_in = 1'b1;
      stall_in = 1'b0;
      flush    = 1'b0;
      for (int k = 1; k < flush_k; k++) begin
         @(negedge clk);
         driveJunk();
         stall_in = 1'b0;
      end
      @(negedge clk);
      driveTxn(plainTxn(EX_ALU, ALU_ADD, B_IMM5));
      valid_in = 1'b1;
      flush    = 1'b1;
      stall_in = 1'($urandom_range(0, 1));
      #1 checkOutput("busy_flush_cycle", 32'(busy), 32'd1);
      @(negedge clk);
      flush    = 1'b0;
      valid_in = 1'b0;
      stall_in = 1'b0;
      #1 checkOutput("busy_after_flush", 32'(busy), 32'd0);
      checkOutput("valid_after_flush", 32'(valid_out), 32'd0);
   endtask

   task automatic resetMidMul(input txn_t t);
      @(negedge clk);
      driveTxn(t);
      valid_in = 1'b1;
      stall_in = 1'b0;
      flush    = 1'b0;
      repeat (3) begin
         @(negedge clk);
         driveJunk();
         stall_in = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1 checkOutput("rst_mid_busy", 32'(busy), 32'd0);
      checkOutput("rst_mid_valid", 32'(valid_out), 32'd0);
      checkOutput("rst_mid_alu", 32'(alu_out), 32'd0);
      checkOutput("rst_mid_pcn", 32'(pcn_out), 32'd0);
      checkOutput("rst_mid_sr2", 32'(sr2_out), 32'd0);
      model_pcn = '0;
      model_sr2 = '0;
      @(negedge clk);
      valid_in = 1'b0;
      rst_n    = 1'b1;
   endtask

   // ---------------- monitor ----------------
   always @(posedge clk) begin
      cyc++;
      was_held = valid_out && stall_in && !flush && rst_n;
      #1;
      if (rst_n && valid_out) begin
         if (was_held) begin
            checkOutput("hold_alu", 32'(alu_out), 32'(last_exp.alu));
            checkOutput("hold_pcn", 32'(pcn_out), 32'(last_exp.pcn));
            checkOutput("hold_sr2", 32'(sr2_out), 32'(last_exp.sr2));
         end else if (sb_q.size() == 0) begin
            checkOutput("unexpected_valid", 32'(valid_out), 32'd0);
         end else begin
            mon_e = sb_q.pop_front();
            checkOutput("res_cycle", 32'(cyc), 32'(mon_e.cyc));
            checkOutput("res_alu", 32'(alu_out), 32'(mon_e.alu));
            checkOutput("res_pcn", 32'(pcn_out), 32'(mon_e.pcn));
            checkOutput("res_sr2", 32'(sr2_out), 32'(mon_e.sr2));
            last_exp = mon_e;
         end
      end
   end

   initial begin
      #2_000_000;
      checkOutput("watchdog", 32'd0, 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // ---------------- main sequence ----------------
   initial begin
      txn_t t;
      rst_n    = 1'b0;
      valid_in = 1'b0;
      flush    = 1'b0;
      stall_in = 1'b0;
      driveTxn(randTxn(0));
      repeat (2) @(negedge clk);
      #1 checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_valid", 32'(valid_out), 32'd0);
      checkOutput("reset_alu", 32'(alu_out), 32'd0);
      checkOutput("reset_pcn", 32'(pcn_out), 32'd0);
      checkOutput("reset_sr2", 32'(sr2_out), 32'd0);
      rst_n = 1'b1;
      $display("[TB] reset released");

      // ADD with imm5 = -1
      t = plainTxn(EX_ALU, ALU_ADD, B_IMM5);
      t.sr1 = 16'h0003;
      t.ir  = 16'h001F;
      applyStimulus(t, 0, 0, 0);

      // 0x0123 * 0x0045
      t = plainTxn(EX_MUL, ALU_ADD, B_SR2);
      t.sr1 = 16'h0123;
      t.sr2 = 16'h0045;
      applyStimulus(t, 0, 0, 0);

      // forwarded A captured at accept, wraps to 0xFFFE
      t = plainTxn(EX_MUL, ALU_ADD, B_SR2);
      t.asel   = SEL_W'(1);
      t.fwd[1] = 16'h7FFF;
      t.sr2    = 16'h0002;
      applyStimulus(t, 0, 0, 1);

      // zero and all-ones operands, stalled three cycles in DONE
      t = plainTxn(EX_MUL, ALU_ADD, B_SR2);
      t.sr1 = 16'hFFFF;
      t.sr2 = 16'hFFFF;
      applyStimulus(t, 0, 3, 2);
      t = plainTxn(EX_MUL, ALU_ADD, B_SR2);
      t.sr1 = 16'h0000;
      applyStimulus(t, 0, 0, 0);

      flushMul(plainTxn(EX_MUL, ALU_ADD, B_SR2), 5);

      resetMidMul(plainTxn(EX_MUL, ALU_ADD, B_SR2));
      t = plainTxn(EX_ALU, ALU_ADD, B_IMM5);
      t.sr1 = 16'h0010;
      t.ir  = 16'h0005;
      applyStimulus(t, 0, 0, 0);

      $display("[TB] directed section done, starting random section");
      for (int n = 0; n < 150; n++) begin
         applyStimulus(randTxn(30), $urandom_range(0, 30), $urandom_range(0, 2),
                       $urandom_range(0, 2));
      end

      repeat (4) begin
         @(negedge clk);
         valid_in = 1'b0;
         stall_in = 1'b0;
         flush    = 1'b0;
      end
      checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
